// File: rtl/instr_injector_pkg.sv
// Shared types and constants for the instruction-injection sequencer.
package instr_injector_pkg;

  localparam logic [3:0] HLT_OPCODE = 4'hF;
  localparam int         OPC_MAXW   = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE,
    ST_TIMEOUT
  } inj_state_e;

  // Top four bits of an instruction of width instr_w, passed zero-extended.
  function automatic logic [3:0] opcode_of(input logic [OPC_MAXW-1:0] instr,
                                           input int                  instr_w);
    return 4'(instr >> (instr_w - 4));
  endfunction

endpackage

// File: rtl/instr_injector_fifo.sv
// Synchronous program FIFO with flush; occupancy counter separates full from empty.
module instr_injector_fifo #(
  parameter int DEPTH   = 32,
  parameter int INSTR_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [INSTR_W-1:0]       din,
  input  logic                     pop,
  input  logic                     flush,
  output logic [INSTR_W-1:0]       head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [INSTR_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wr;
  logic [AW-1:0]      r_rd;
  logic [AW:0]        r_level;

  // Storage array; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr] <= din;
  end

  // Pointers wrap naturally (DEPTH is a power of 2); flush discards everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else if (flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (push) r_wr <= r_wr + 1'b1;
      if (pop)  r_rd <= r_rd + 1'b1;
      case ({push, pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign head  = r_mem[r_rd];
  assign full  = (r_level == (AW+1)'(DEPTH));
  assign empty = (r_level == '0);
  assign level = r_level;

endmodule

// File: rtl/instr_injector.sv
// Instruction-injection sequencer: buffers a program and streams it into the cpu
// one word per cycle until halt or cycle-budget timeout.
module instr_injector
  import instr_injector_pkg::*;
#(
  parameter int               INSTR_W    = 16,
  parameter int               DEPTH      = 32,
  parameter int               TIMEOUT    = 100000,
  parameter logic [3:0]       HLT_OP     = HLT_OPCODE,
  parameter logic [INSTR_W-1:0] FILL_INSTR = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           load_valid,
  input  logic [INSTR_W-1:0]             load_instr,
  output logic                           load_ready,
  input  logic                           start,
  input  logic                           clear,
  input  logic                           hlt_in,
  output logic [INSTR_W-1:0]             instr_out,
  output logic                           mode_out,
  output logic                           busy,
  output logic                           done,
  output logic                           timed_out,
  output logic [$clog2(DEPTH)+7:0]       issued_cnt,
  output logic [$clog2(TIMEOUT+1)-1:0]   cycle_cnt,
  output logic [$clog2(DEPTH):0]         level
);

  localparam int             IW       = $clog2(DEPTH) + 8;
  localparam int             CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  CYC_LAST = CW'(TIMEOUT - 1);

  inj_state_e          r_state, w_state_nxt;
  logic [INSTR_W-1:0]  r_instr, w_instr_nxt;
  logic [IW-1:0]       r_issued;
  logic [CW-1:0]       r_cycle;
  logic [INSTR_W-1:0]  w_head;
  logic                w_full, w_empty;
  logic                w_push, w_pop, w_flush;
  logic                w_clr_cnt, w_cnt_en, w_cyc_last;

  assign w_cyc_last = (r_cycle == CYC_LAST);
  assign load_ready = !w_full && (r_state == ST_IDLE || r_state == ST_RUN);
  assign w_push     = load_valid && load_ready;

  instr_injector_fifo #(
    .DEPTH   (DEPTH),
    .INSTR_W (INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .din   (load_instr),
    .pop   (w_pop),
    .flush (w_flush),
    .head  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (level)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and per-cycle control; timeout outranks hlt_in, and a cycle
  // that ends the run issues nothing.
  always_comb begin
    w_state_nxt = r_state;
    w_instr_nxt = FILL_INSTR;
    w_pop       = 1'b0;
    w_flush     = 1'b0;
    w_clr_cnt   = 1'b0;
    w_cnt_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_clr_cnt   = 1'b1;
        end
      end
      ST_RUN: begin
        w_cnt_en = 1'b1;
        if (w_cyc_last) begin
          w_state_nxt = ST_TIMEOUT;
        end else if (hlt_in) begin
          w_state_nxt = ST_DONE;
        end else if (!w_empty) begin
          w_pop       = 1'b1;
          w_instr_nxt = w_head;
          if (opcode_of(OPC_MAXW'(w_head), INSTR_W) == HLT_OP) w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_cnt_en = 1'b1;
        if (w_cyc_last)  w_state_nxt = ST_TIMEOUT;
        else if (hlt_in) w_state_nxt = ST_DONE;
      end
      ST_DONE, ST_TIMEOUT: begin
        if (clear) begin
          w_state_nxt = ST_IDLE;
          w_flush     = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Issued instruction register and run counters (frozen outside RUN/DRAIN).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr  <= FILL_INSTR;
      r_issued <= '0;
      r_cycle  <= '0;
    end else begin
      r_instr <= w_instr_nxt;
      if (w_clr_cnt) begin
        r_issued <= '0;
        r_cycle  <= '0;
      end else begin
        if (w_cnt_en) r_cycle <= r_cycle + 1'b1;
        if (w_pop && r_issued != '1) r_issued <= r_issued + 1'b1;
      end
    end
  end

  assign instr_out  = r_instr;
  assign busy       = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign mode_out   = busy;
  assign done       = (r_state == ST_DONE);
  assign timed_out  = (r_state == ST_TIMEOUT);
  assign issued_cnt = r_issued;
  assign cycle_cnt  = r_cycle;

endmodule
